// File: rtl/ray_bbox_isect.sv
// ray_bbox_isect
// ---------------------------------------------------------------------------
// Fully pipelined ray / axis-aligned bounding-box slab test for BVH traversal.
// Each accepted request carries a ray (origin and reciprocal direction), a
// bbox, a valid t interval and an opaque tag. The result is hit/miss, the
// clipped entry/exit distances and the unchanged tag. All data words are
// signed fixed point Q(W-FRAC).FRAC.
//
// Pipeline (one register level per step, every level has its own valid bit):
//   S1 regs : accepted request
//   S2 regs : slab differences bmin-orig / bmax-orig (W+1 bits)
//   S3 regs : slab distances t = (d * inv) >>> FRAC, reduced to W bits
//   S4 regs : per-axis lo = min(t0,t1), hi = max(t0,t1)
//   out regs: t_near/t_far clipped against [t_min, t_max], hit, tag
// A request accepted at edge N shows out_valid=1 after edge N+4.
// One global advance enable moves everything, bubbles included, so results
// leave strictly in acceptance order and the pipe never compacts on a stall.
//
// Configuration macro: RAY_BBOX_SAT_EN
//   defined   : the S2 product saturates to the W-bit signed range, which
//               makes the max/min "infinity" encoding of inv_* safe.
//   undefined : the S2 product is truncated to its low W bits (wraps).
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      request handshake (in_ready = advance enable)
//   orig_x/y/z               ray origin
//   inv_x/y/z                reciprocal ray direction
//   bmin_x/y/z, bmax_x/y/z   bbox corners (bmin <= bmax per axis)
//   t_min, t_max             valid ray interval
//   in_tag                   request tag
//   out_valid / out_ready    result handshake
//   hit, t_near, t_far       result; t_near/t_far are driven even on a miss
//   out_tag                  tag of the result
// ---------------------------------------------------------------------------
module ray_bbox_isect #(
  parameter int W     = 28,
  parameter int FRAC  = 16,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     orig_x,
  input  logic [W-1:0]     orig_y,
  input  logic [W-1:0]     orig_z,
  input  logic [W-1:0]     inv_x,
  input  logic [W-1:0]     inv_y,
  input  logic [W-1:0]     inv_z,
  input  logic [W-1:0]     bmin_x,
  input  logic [W-1:0]     bmin_y,
  input  logic [W-1:0]     bmin_z,
  input  logic [W-1:0]     bmax_x,
  input  logic [W-1:0]     bmax_y,
  input  logic [W-1:0]     bmax_z,
  input  logic [W-1:0]     t_min,
  input  logic [W-1:0]     t_max,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             hit,
  output logic [W-1:0]     t_near,
  output logic [W-1:0]     t_far,
  output logic [TAG_W-1:0] out_tag
);

  localparam int AX = 3;

  // Reduce the shifted (2W+1)-bit slab product to a W-bit distance.
  function automatic logic signed [W-1:0] reduce_t(input logic signed [2*W:0] p);
`ifdef RAY_BBOX_SAT_EN
    logic signed [2*W:0] s;
    s = p >>> FRAC;
    // Fits in W bits only if everything above the W-bit sign bit is a copy of it.
    if (s[2*W:W-1] != {(W+2){s[2*W]}})
      reduce_t = s[2*W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    else
      reduce_t = s[W-1:0];
`else
    reduce_t = W'(p >>> FRAC);
`endif
  endfunction

  // Global advance: the whole pipe moves unless a result is waiting unread.
  logic adv;

  // Per-axis views of the request ports.
  logic signed [W-1:0] orig_a [AX];
  logic signed [W-1:0] inv_a  [AX];
  logic signed [W-1:0] bmin_a [AX];
  logic signed [W-1:0] bmax_a [AX];

  assign orig_a[0] = orig_x;  assign orig_a[1] = orig_y;  assign orig_a[2] = orig_z;
  assign inv_a[0]  = inv_x;   assign inv_a[1]  = inv_y;   assign inv_a[2]  = inv_z;
  assign bmin_a[0] = bmin_x;  assign bmin_a[1] = bmin_y;  assign bmin_a[2] = bmin_z;
  assign bmax_a[0] = bmax_x;  assign bmax_a[1] = bmax_y;  assign bmax_a[2] = bmax_z;

  // S1: accepted request
  logic                s1_v_q;
  logic signed [W-1:0] s1_orig_q [AX];
  logic signed [W-1:0] s1_inv_q  [AX];
  logic signed [W-1:0] s1_bmin_q [AX];
  logic signed [W-1:0] s1_bmax_q [AX];
  logic signed [W-1:0] s1_tmin_q, s1_tmax_q;
  logic [TAG_W-1:0]    s1_tag_q;

  // S2: slab differences
  logic                s2_v_q;
  logic signed [W:0]   s2_d0_d [AX];
  logic signed [W:0]   s2_d1_d [AX];
  logic signed [W:0]   s2_d0_q [AX];
  logic signed [W:0]   s2_d1_q [AX];
  logic signed [W-1:0] s2_inv_q [AX];
  logic signed [W-1:0] s2_tmin_q, s2_tmax_q;
  logic [TAG_W-1:0]    s2_tag_q;

  // S3: slab distances
  logic                s3_v_q;
  logic signed [W-1:0] s3_t0_d [AX];
  logic signed [W-1:0] s3_t1_d [AX];
  logic signed [W-1:0] s3_t0_q [AX];
  logic signed [W-1:0] s3_t1_q [AX];
  logic signed [W-1:0] s3_tmin_q, s3_tmax_q;
  logic [TAG_W-1:0]    s3_tag_q;

  // S4: per-axis entry/exit
  logic                s4_v_q;
  logic signed [W-1:0] s4_lo_d [AX];
  logic signed [W-1:0] s4_hi_d [AX];
  logic signed [W-1:0] s4_lo_q [AX];
  logic signed [W-1:0] s4_hi_q [AX];
  logic signed [W-1:0] s4_tmin_q, s4_tmax_q;
  logic [TAG_W-1:0]    s4_tag_q;

  // Output registers
  logic                out_valid_q;
  logic                hit_q, hit_d;
  logic signed [W-1:0] t_near_q, t_near_d;
  logic signed [W-1:0] t_far_q, t_far_d;
  logic [TAG_W-1:0]    out_tag_q;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  for (genvar gi = 0; gi < AX; gi++) begin : g_axis
    logic signed [2*W:0] p0, p1;

    // S1 -> S2: one extra bit so the difference never overflows.
    assign s2_d0_d[gi] = {s1_bmin_q[gi][W-1], s1_bmin_q[gi]} - {s1_orig_q[gi][W-1], s1_orig_q[gi]};
    assign s2_d1_d[gi] = {s1_bmax_q[gi][W-1], s1_bmax_q[gi]} - {s1_orig_q[gi][W-1], s1_orig_q[gi]};

    // S2 -> S3: both operands sign-extended to the full product width.
    assign p0 = $signed({{W{s2_d0_q[gi][W]}}, s2_d0_q[gi]})
              * $signed({{(W+1){s2_inv_q[gi][W-1]}}, s2_inv_q[gi]});
    assign p1 = $signed({{W{s2_d1_q[gi][W]}}, s2_d1_q[gi]})
              * $signed({{(W+1){s2_inv_q[gi][W-1]}}, s2_inv_q[gi]});
    assign s3_t0_d[gi] = reduce_t(p0);
    assign s3_t1_d[gi] = reduce_t(p1);

    // S3 -> S4: a negative reciprocal swaps which plane is entered first.
    assign s4_lo_d[gi] = (s3_t0_q[gi] < s3_t1_q[gi]) ? s3_t0_q[gi] : s3_t1_q[gi];
    assign s4_hi_d[gi] = (s3_t0_q[gi] < s3_t1_q[gi]) ? s3_t1_q[gi] : s3_t0_q[gi];
  end

  // S4 -> out: intersect the three slabs with the ray interval.
  always_comb begin
    t_near_d = s4_tmin_q;
    t_far_d  = s4_tmax_q;
    for (int a = 0; a < AX; a++) begin
      if (s4_lo_q[a] > t_near_d) t_near_d = s4_lo_q[a];
      if (s4_hi_q[a] < t_far_d)  t_far_d  = s4_hi_q[a];
    end
    hit_d = (t_near_d <= t_far_d);
  end

  // Stage data: no reset needed, qualified by the valid bits below.
  always_ff @(posedge clk) begin
    if (adv) begin
      for (int a = 0; a < AX; a++) begin
        s1_orig_q[a] <= orig_a[a];
        s1_inv_q[a]  <= inv_a[a];
        s1_bmin_q[a] <= bmin_a[a];
        s1_bmax_q[a] <= bmax_a[a];
        s2_d0_q[a]   <= s2_d0_d[a];
        s2_d1_q[a]   <= s2_d1_d[a];
        s2_inv_q[a]  <= s1_inv_q[a];
        s3_t0_q[a]   <= s3_t0_d[a];
        s3_t1_q[a]   <= s3_t1_d[a];
        s4_lo_q[a]   <= s4_lo_d[a];
        s4_hi_q[a]   <= s4_hi_d[a];
      end
      s1_tmin_q <= t_min;      s1_tmax_q <= t_max;      s1_tag_q <= in_tag;
      s2_tmin_q <= s1_tmin_q;  s2_tmax_q <= s1_tmax_q;  s2_tag_q <= s1_tag_q;
      s3_tmin_q <= s2_tmin_q;  s3_tmax_q <= s2_tmax_q;  s3_tag_q <= s2_tag_q;
      s4_tmin_q <= s3_tmin_q;  s4_tmax_q <= s3_tmax_q;  s4_tag_q <= s3_tag_q;
    end
  end

  // Valid chain and visible outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q      <= 1'b0;
      s2_v_q      <= 1'b0;
      s3_v_q      <= 1'b0;
      s4_v_q      <= 1'b0;
      out_valid_q <= 1'b0;
      hit_q       <= 1'b0;
      t_near_q    <= '0;
      t_far_q     <= '0;
      out_tag_q   <= '0;
    end else if (adv) begin
      s1_v_q      <= in_valid;
      s2_v_q      <= s1_v_q;
      s3_v_q      <= s2_v_q;
      s4_v_q      <= s3_v_q;
      out_valid_q <= s4_v_q;
      // Outputs keep the last real result while bubbles pass.
      if (s4_v_q) begin
        hit_q     <= hit_d;
        t_near_q  <= t_near_d;
        t_far_q   <= t_far_d;
        out_tag_q <= s4_tag_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign hit       = hit_q;
  assign t_near    = t_near_q;
  assign t_far     = t_far_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_ray_bbox_isect.sv
// Bench for ray_bbox_isect: directed cases with hand-derived results, a
// backpressure stream, a mid-flight reset and a randomized run checked
// against a plain-arithmetic slab model.
module tb_ray_bbox_isect;

  localparam int W     = 28;
  localparam int FRAC  = 16;
  localparam int TAG_W = 8;
  localparam int ONE   = 1 << FRAC;

  typedef struct {
    logic [2:0][W-1:0] o, iv, bn, bx;
    logic [W-1:0]      tmin, tmax;
    logic [TAG_W-1:0]  tag;
  } req_t;

  typedef struct {
    logic             hit;
    logic [W-1:0]     near, far;
    logic [TAG_W-1:0] tag;
    bit               lat;
    int               acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, in_ready;
  logic [W-1:0] orig_x = '0, orig_y = '0, orig_z = '0;
  logic [W-1:0] inv_x = '0, inv_y = '0, inv_z = '0;
  logic [W-1:0] bmin_x = '0, bmin_y = '0, bmin_z = '0;
  logic [W-1:0] bmax_x = '0, bmax_y = '0, bmax_z = '0;
  logic [W-1:0] t_min = '0, t_max = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic out_valid, out_ready = 1'b1, hit;
  logic [W-1:0] t_near, t_far;
  logic [TAG_W-1:0] out_tag;

  int n_checks = 0;
  int n_pass   = 0;
  int iter     = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  ray_bbox_isect #(.W(W), .FRAC(FRAC), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .orig_x(orig_x), .orig_y(orig_y), .orig_z(orig_z),
    .inv_x(inv_x), .inv_y(inv_y), .inv_z(inv_z),
    .bmin_x(bmin_x), .bmin_y(bmin_y), .bmin_z(bmin_z),
    .bmax_x(bmax_x), .bmax_y(bmax_y), .bmax_z(bmax_z),
    .t_min(t_min), .t_max(t_max), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .hit(hit),
    .t_near(t_near), .t_far(t_far), .out_tag(out_tag)
  );

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, obs, exp, iter);
  endtask

  // ---------------- reference model ----------------
  function automatic longint sx(input logic [W-1:0] v);
    logic signed [W-1:0] s;
    s = v;
    return longint'(s);
  endfunction

  function automatic longint red(input longint p);
    longint s;
    s = p >>> FRAC;
`ifdef RAY_BBOX_SAT_EN
    if (s > (64'sd1 <<< (W-1)) - 1) s = (64'sd1 <<< (W-1)) - 1;
    if (s < -(64'sd1 <<< (W-1)))    s = -(64'sd1 <<< (W-1));
`else
    s = s & ((64'sd1 <<< W) - 1);
    if (s >= (64'sd1 <<< (W-1))) s = s - (64'sd1 <<< W);
`endif
    return s;
  endfunction

  function automatic exp_t model(input req_t r);
    exp_t e;
    longint t0, t1, nr, fr;
    nr = sx(r.tmin);
    fr = sx(r.tmax);
    for (int a = 0; a < 3; a++) begin
      t0 = red((sx(r.bn[a]) - sx(r.o[a])) * sx(r.iv[a]));
      t1 = red((sx(r.bx[a]) - sx(r.o[a])) * sx(r.iv[a]));
      if ((t0 < t1 ? t0 : t1) > nr) nr = (t0 < t1 ? t0 : t1);
      if ((t0 < t1 ? t1 : t0) < fr) fr = (t0 < t1 ? t1 : t0);
    end
    e.hit  = (nr <= fr);
    e.near = nr[W-1:0];
    e.far  = fr[W-1:0];
    e.tag  = r.tag;
    e.lat  = 1'b0;
    e.acc  = 0;
    return e;
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic logic [W-1:0] rnd(input int span);
    int v;
    v = int'($urandom_range(0, 2 * span)) - span;
    return W'(v);
  endfunction

  function automatic req_t rand_req(input logic [TAG_W-1:0] tag);
    req_t r;
    logic [W-1:0] a0, a1;
    int tmin_i;
    for (int a = 0; a < 3; a++) begin
      r.o[a] = rnd(16 * ONE);
      a0 = rnd(16 * ONE);
      a1 = rnd(16 * ONE);
      r.bn[a] = (sx(a0) <= sx(a1)) ? a0 : a1;
      r.bx[a] = (sx(a0) <= sx(a1)) ? a1 : a0;
      case ($urandom_range(0, 9))
        0:       r.iv[a] = {1'b0, {(W-1){1'b1}}};
        1:       r.iv[a] = {1'b1, {(W-1){1'b0}}};
        default: r.iv[a] = rnd(4 * ONE);
      endcase
    end
    tmin_i = int'($urandom_range(0, 4 * ONE)) - 2 * ONE;
    r.tmin = W'(tmin_i);
    r.tmax = W'(tmin_i + int'($urandom_range(0, 30 * ONE)));
    r.tag  = tag;
    return r;
  endfunction

  function automatic req_t dir_req(input int o, input int iv, input int bn, input int bx,
                                   input int tmax, input logic [TAG_W-1:0] tag);
    req_t r;
    for (int a = 0; a < 3; a++) begin
      r.o[a] = W'(o); r.iv[a] = W'(iv); r.bn[a] = W'(bn); r.bx[a] = W'(bx);
    end
    r.tmin = '0;
    r.tmax = W'(tmax);
    r.tag  = tag;
    return r;
  endfunction

  function automatic exp_t mk_exp(input logic h, input int nr, input int fr);
    exp_t e;
    e.hit = h; e.near = W'(nr); e.far = W'(fr);
    e.tag = '0; e.lat = 1'b1; e.acc = 0;
    return e;
  endfunction

  // One clock cycle: drive at the falling edge, observe 1 time unit later,
  // and account for the transfers that the next rising edge will perform.
  task automatic cycle(input bit iv, input req_t r, input bit ordy,
                       input bit use_ovr, input exp_t ovr, output bit acc);
    exp_t e;
    @(negedge clk);
    in_valid = iv; out_ready = ordy;
    orig_x = r.o[0];  orig_y = r.o[1];  orig_z = r.o[2];
    inv_x  = r.iv[0]; inv_y  = r.iv[1]; inv_z  = r.iv[2];
    bmin_x = r.bn[0]; bmin_y = r.bn[1]; bmin_z = r.bn[2];
    bmax_x = r.bx[0]; bmax_y = r.bx[1]; bmax_z = r.bx[2];
    t_min = r.tmin; t_max = r.tmax; in_tag = r.tag;
    #1;
    check("in_ready", in_ready, !(out_valid && !out_ready));
    if (out_valid && out_ready) begin
      if (sb.size() == 0) check("spurious_result", 1, 0);
      else begin
        e = sb.pop_front();
        check("tag", out_tag, e.tag);
        check("hit", hit, e.hit);
        check("t_near", t_near, e.near);
        check("t_far", t_far, e.far);
        if (e.lat) check("latency", iter - 1 - e.acc, 4);
      end
    end
    acc = iv && in_ready;
    if (acc) begin
      e = use_ovr ? ovr : model(r);
      e.tag = r.tag;
      e.lat = use_ovr;
      e.acc = iter;
      sb.push_back(e);
    end
    iter++;
  endtask

  task automatic drain();
    bit a;
    req_t r;
    exp_t x;
    r = dir_req(0, 0, 0, 0, 0, 0);
    x = mk_exp(0, 0, 0);
    for (int i = 0; i < 40 && sb.size() != 0; i++) cycle(1'b0, r, 1'b1, 1'b0, x, a);
    check("drain_pending", sb.size(), 0);
  endtask

  // Directed single request on an idle pipe with spec-derived expectations.
  task automatic run_one(input req_t r, input exp_t x);
    bit a;
    a = 1'b0;
    for (int i = 0; i < 10 && !a; i++) cycle(1'b1, r, 1'b1, 1'b1, x, a);
    check("accepted", a, 1);
    drain();
  endtask

  task automatic reset_and_check();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_hit", hit, 0);
    check("rst_t_near", t_near, 0);
    check("rst_t_far", t_far, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_in_ready", in_ready, 1);
    sb.delete();
    iter += 2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t r, bp[7];
    exp_t x;
    bit a;
    int nxt;

    repeat (2) @(negedge clk);
    reset_and_check();

    // Axis-aligned unit ray into bbox (1..2)^3.
    r = dir_req(0, ONE, ONE, 2 * ONE, 10 * ONE, 8'h01);
    run_one(r, mk_exp(1'b1, ONE, 2 * ONE));

    // y slab shifted to [3,4]: entry after exit -> miss, values still clipped.
    r = dir_req(0, ONE, ONE, 2 * ONE, 10 * ONE, 8'h02);
    r.bn[1] = W'(3 * ONE); r.bx[1] = W'(4 * ONE);
    run_one(r, mk_exp(1'b0, 3 * ONE, 2 * ONE));

    // Negative direction from (3,3,3).
    r = dir_req(3 * ONE, -ONE, ONE, 2 * ONE, 10 * ONE, 8'h03);
    run_one(r, mk_exp(1'b1, ONE, 2 * ONE));
    r.tmax = W'(32'h8000);  r.tag = 8'h04;
    run_one(r, mk_exp(1'b0, ONE, 32'h8000));
    r.tmax = W'(32'h18000); r.tag = 8'h05;
    run_one(r, mk_exp(1'b1, ONE, 32'h18000));

    // Product overflow on x: inv_x is the max word.
    r = dir_req(0, ONE, -10 * ONE, 20 * ONE, 32'h7FFFFFF, 8'h06);
    r.iv[0] = W'(32'h7FFFFFF); r.bn[0] = W'(ONE); r.bx[0] = W'(ONE);
    run_one(r, mk_exp(1'b0, 32'h7FFFFFF, 20 * ONE));
    r.bn[0] = W'(2 * ONE); r.bx[0] = W'(2 * ONE); r.tag = 8'h07;
`ifdef RAY_BBOX_SAT_EN
    run_one(r, mk_exp(1'b0, 32'h7FFFFFF, 20 * ONE));
`else
    run_one(r, mk_exp(1'b0, 0, 32'hFFFFFFE));
`endif

    // Backpressure: six back-to-back requests, out_ready low for 3 cycles.
    for (int k = 0; k < 7; k++) bp[k] = rand_req(TAG_W'(k));
    nxt = 0;
    x = mk_exp(0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      cycle(nxt < 6, bp[nxt], !(i >= 5 && i <= 7), 1'b0, x, a);
      if (a) nxt++;
    end
    check("bp_sent", nxt, 6);
    drain();

    // Mid-flight reset: three requests in the pipe are discarded.
    for (int k = 0; k < 3; k++) cycle(1'b1, rand_req(TAG_W'(8'hE0 + k)), 1'b1, 1'b0, x, a);
    reset_and_check();
    r = dir_req(0, ONE, ONE, 2 * ONE, 10 * ONE, 8'h08);
    run_one(r, mk_exp(1'b1, ONE, 2 * ONE));

    // Randomized traffic with random stalls.
    r = rand_req(8'h10);
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, r, $urandom_range(0, 3) != 0, 1'b0, x, a);
      if (a) r = rand_req(TAG_W'(8'h10 + i));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ray_bbox_isect.md
# ray_bbox_isect

Parametrised, fully pipelined ray / axis-aligned bounding-box slab intersection unit for the BVH traversal path. Each accepted request carries a ray (origin and precomputed reciprocal direction), a bbox, a valid t interval and a tag. It returns hit/miss, the clipped entry and exit distances, and the tag. Data words are signed fixed-point of width W with FRAC fractional bits; the defaults match the team's 28-bit point/vec3 format.

## Interface
- W, 28, signed word width of every coordinate, reciprocal and t value
- FRAC, 16, fractional bits (Q(W-FRAC).FRAC)
- TAG_W, 8, width of the opaque tag passed through unchanged
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- orig_x/y/z  in  W each  ray origin
- inv_x/y/z  in  W each  reciprocal ray direction; infinity is encoded as the max positive or min negative word
- bmin_x/y/z, bmax_x/y/z  in  W each  bbox corners, with bmin <= bmax per axis
- t_min, t_max  in  W each  valid ray interval
- in_tag  in  TAG_W  request tag
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- hit  out  1  intersection in [t_min, t_max]
- t_near, t_far  out  W each  clipped entry and exit distances
- out_tag  out  TAG_W  tag of the result

## Operation
- Four stages (S1–S4), each with its own valid bit. There is one global advance enable: adv = !out_valid || out_ready. in_ready = adv.
- S1: six differences d = bmin_a − orig_a and bmax_a − orig_a, each W+1 bits signed.
- S2: t = (d × inv_a) >>> FRAC, arithmetic shift, 2W+1-bit product. The result is reduced to W bits as set under Configuration.
- S3: per axis, lo_a = min(t0_a, t1_a) and hi_a = max(t0_a, t1_a), signed compares.
- S4: t_near = max(lo_x, lo_y, lo_z, t_min); t_far = min(hi_x, hi_y, hi_z, t_max); hit = (t_near <= t_far). Equality counts as a hit. The stage registers outputs and tag.
- t_near and t_far are always driven with the clipped values, including on a miss.
- Results leave in acceptance order. There is no reordering and no dropping.
- A bubble, i.e. an invalid stage, moves through the pipeline like data. The pipeline never compacts while stalled.
- Reset: all stage valid bits clear; out_valid=0, hit=0, t_near=0, t_far=0, out_tag=0; in_ready=1 in the first cycle after reset deasserts.
- Reset mid-operation discards every in-flight request silently.

## Timing
- Latency is 4 cycles. A request accepted at edge N gives out_valid=1 after edge N+4, provided adv stays high.
- Throughput is one request per cycle with out_ready held high.
- When out_valid && !out_ready, all stages hold and in_ready=0 in the same cycle (combinational from out_ready). Outputs stay stable until consumed.
- When a result is consumed and a new request is accepted in the same cycle, both transfers happen and the pipeline shifts by one.
- in_ready does not depend on in_valid.
- Inputs are sampled only on an accepting edge; the upstream block may change them freely otherwise.

## Configuration
- RAY_BBOX_SAT_EN defined: the S2 product is saturated to the range [−2^(W−1), 2^(W−1)−1]. This makes the infinity encoding of inv_* safe.
- RAY_BBOX_SAT_EN undefined: the S2 product is truncated to its low W bits, which wraps. This saves area, and the upstream block must guarantee no overflow.

## Test plan
- Defaults, orig (0,0,0), inv (1.0,1.0,1.0)=0x10000 each, bbox (1,1,1)–(2,2,2), t_min=0, t_max=10.0 -> hit=1, t_near=0x10000, t_far=0x20000, out_valid exactly 4 cycles after accept.
- Same as the first case but bbox y in [3,4] -> t_near=0x30000, t_far=0x20000, hit=0.
- orig (3,3,3), inv (−1.0 ×3), bbox (1,1,1)–(2,2,2) -> hit=1, t_near=0x10000, t_far=0x20000. Then t_max=0x8000 -> hit=0; t_max=0x18000 -> hit=1, t_far=0x18000.
- Backpressure: six back-to-back requests with tags 0..5, out_ready low for 3 cycles mid-stream -> all six results appear in tag order with correct values; in_ready=0 exactly while out_valid && !out_ready.
- Overflow: inv_x=0x7FFFFFF, d_x=1.0. With RAY_BBOX_SAT_EN, t=0x7FFFFFF. Without it, t equals the low 28 bits of the shifted product.
- Reset: assert rst for 1 cycle with 3 requests in flight -> out_valid=0 and all outputs 0 on the next cycle, none of the 3 results ever appear, and a new request completes 4 cycles after acceptance.
